// File: rtl/ws2812b_encoder.sv
// WS2812B NRZ serialiser: 24-bit GRB pixels in over valid/ready, MSB-first pulses on dout,
// automatic latch gap once the pixel stream runs dry.
module ws2812b_encoder #(
  parameter int CLK_HZ       = 64000000,
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int BIT_CYCLES   = 80,
  parameter int LATCH_CYCLES = 5120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam int PHASE_W = $clog2(BIT_CYCLES);
  localparam int LATCH_W = $clog2(LATCH_CYCLES);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] T0H_P      = PHASE_W'(T0H_CYCLES);
  localparam logic [PHASE_W-1:0] T1H_P      = PHASE_W'(T1H_CYCLES);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [4:0]         BIT_LAST   = 5'd23;

  if (CLK_HZ <= 0 || T0H_CYCLES >= T1H_CYCLES || T1H_CYCLES >= BIT_CYCLES || LATCH_CYCLES < 2)
  begin : g_param_check
    $error("ws2812b_encoder: inconsistent timing parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } state_t;

  state_t               state, state_next;
  logic [23:0]          hold, hold_next;
  logic                 hold_full, hold_full_next;
  logic [23:0]          shifter, shifter_next;
  logic [PHASE_W-1:0]   phase, phase_next;
  logic [4:0]           bit_idx, bit_idx_next;
  logic [LATCH_W-1:0]   latch_cnt, latch_cnt_next;
  logic                 dout_next;
  logic                 done_next;
  logic                 accept;

  assign pixel_ready = !hold_full;
  assign accept      = pixel_valid && !hold_full;
  assign busy        = (state != IDLE) || hold_full;

  // Register all state; synchronous reset discards hold and shifter without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      latch_cnt <= '0;
      dout      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      hold      <= hold_next;
      hold_full <= hold_full_next;
      shifter   <= shifter_next;
      phase     <= phase_next;
      bit_idx   <= bit_idx_next;
      latch_cnt <= latch_cnt_next;
      dout      <= dout_next;
      done      <= done_next;
    end
  end

  // Next-state, holding register, bit timing and registered-output precompute.
  always_comb begin
    state_next     = state;
    hold_next      = hold;
    hold_full_next = hold_full;
    shifter_next   = shifter;
    phase_next     = phase;
    bit_idx_next   = bit_idx;
    latch_cnt_next = latch_cnt;
    dout_next      = 1'b0;
    done_next      = 1'b0;

    if (accept) begin
      hold_next      = pixel_data;
      hold_full_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_full) begin
          shifter_next   = hold;
          hold_full_next = 1'b0;
          phase_next     = '0;
          bit_idx_next   = '0;
          state_next     = SEND;
        end
      end

      SEND: begin
        dout_next = (phase < (shifter[23] ? T1H_P : T0H_P));
        if (phase == PHASE_LAST) begin
          phase_next = '0;
          if (bit_idx != BIT_LAST) begin
            shifter_next = {shifter[22:0], 1'b0};
            bit_idx_next = bit_idx + 5'd1;
          end else begin
            bit_idx_next = '0;
            if (hold_full) begin
              shifter_next   = hold;
              hold_full_next = 1'b0;
            end else if (accept) begin
              // Bypass: the pixel arriving on the end-of-pixel cycle goes straight to the shifter.
              shifter_next   = pixel_data;
              hold_next      = hold;
              hold_full_next = 1'b0;
            end else begin
              latch_cnt_next = '0;
              state_next     = LATCH;
            end
          end
        end else begin
          phase_next = phase + 1'b1;
        end
      end

      LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          latch_cnt_next = latch_cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_encoder.sv
// Self-checking bench for ws2812b_encoder: random pixels, pulse-level reference model.
module tb_ws2812b_encoder;

  localparam int T0H      = 26;
  localparam int T1H      = 51;
  localparam int BITP     = 80;
  localparam int LATCH    = 5120;
  localparam int DEC_THR  = 38;
  localparam int IDLE_WIN = 3840;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        dout;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int rise_q[$];
  int width_q[$];
  int done_q[$];
  int idle_q[$];
  bit dec_q[$];
  int hi_start = 0;
  int lowrun   = 0;
  bit prev_dout = 1'b0;

  ws2812b_encoder #(
    .CLK_HZ      (64000000),
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .BIT_CYCLES  (BITP),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .dout       (dout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: pulse edges, decoded bits (threshold decoder), idle events, done pulses.
  always @(negedge clk) begin
    if (dout && !prev_dout) begin
      rise_q.push_back(cyc);
      hi_start = cyc;
    end
    if (!dout && prev_dout) begin
      width_q.push_back(cyc - hi_start);
      dec_q.push_back((cyc - hi_start) > DEC_THR);
    end
    if (dout) lowrun = 0;
    else if (lowrun < 1000000) lowrun = lowrun + 1;
    if (!dout && lowrun == IDLE_WIN) idle_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    prev_dout = dout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int exp_hi(input bit b);
    return b ? T1H : T0H;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input logic [23:0] px, input bit keep, output int acc);
    int guard;
    acc = -1;
    guard = 0;
    pixel_data = px;
    pixel_valid = 1'b1;
    while (!pixel_ready && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (pixel_ready) acc = cyc;
    else begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: pixel_ready=%b, required 1", pixel_ready);
    end
    @(negedge clk);
    if (!keep) pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_valid = 1'b0;
    pixel_data = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (dout !== 1'b0) begin n_err++; $display("FAIL reset_dout: got %b want 0", dout); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", pixel_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pixel(input logic [23:0] px);
    int rb, wb, db, acc, nr;
    bit eb[$];
    rb = rise_q.size(); wb = width_q.size(); db = done_q.size();
    for (int b = 23; b >= 0; b--) eb.push_back(px[b]);
    push(px, 1'b0, acc);
    wait_cyc(acc + 2 + 24 * BITP + LATCH + 10);
    nr = rise_q.size() - rb;
    n_vec++; if (nr !== 24) begin n_err++; $display("FAIL single_rises: got %0d want 24", nr); end
    for (int k = 0; k < 24 && k < nr && wb + k < width_q.size(); k++) begin
      n_vec++;
      if (rise_q[rb + k] !== acc + 3 + k * BITP) begin
        n_err++; $display("FAIL single_rise bit %0d: got %0d want %0d", k, rise_q[rb + k], acc + 3 + k * BITP);
      end
      n_vec++;
      if (width_q[wb + k] !== exp_hi(eb[k])) begin
        n_err++; $display("FAIL single_width bit %0d: got %0d want %0d", k, width_q[wb + k], exp_hi(eb[k]));
      end
    end
    n_vec++; if (done_q.size() - db !== 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", done_q.size() - db); end
    if (done_q.size() > db) begin
      n_vec++;
      if (done_q[db] !== acc + 2 + 24 * BITP + LATCH) begin
        n_err++; $display("FAIL single_done_cycle: got %0d want %0d", done_q[db], acc + 2 + 24 * BITP + LATCH);
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back(input logic [23:0] p0, input logic [23:0] p1);
    int rb, wb, db, a0, a1, nr, t_done, n_idle;
    bit eb[$];
    rb = rise_q.size(); wb = width_q.size(); db = done_q.size();
    for (int b = 23; b >= 0; b--) eb.push_back(p0[b]);
    for (int b = 23; b >= 0; b--) eb.push_back(p1[b]);
    push(p0, 1'b0, a0);
    wait_cyc(a0 + 100 + $urandom_range(0, 1500));
    push(p1, 1'b0, a1);
    n_vec++; if (pixel_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_fall: got %b want 0", pixel_ready); end
    wait_cyc(a0 + 2 + 24 * BITP - 1);
    n_vec++; if (pixel_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_before_drain: got %b want 0", pixel_ready); end
    wait_cyc(a0 + 2 + 24 * BITP);
    n_vec++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_drain: got %b want 1", pixel_ready); end
    t_done = a0 + 2 + 48 * BITP + LATCH;
    wait_cyc(t_done + 100);
    nr = rise_q.size() - rb;
    n_vec++; if (nr !== 48) begin n_err++; $display("FAIL b2b_rises: got %0d want 48", nr); end
    for (int k = 0; k < 48 && k < nr && wb + k < width_q.size(); k++) begin
      n_vec++;
      if (rise_q[rb + k] !== a0 + 3 + k * BITP) begin
        n_err++; $display("FAIL b2b_rise bit %0d: got %0d want %0d", k, rise_q[rb + k], a0 + 3 + k * BITP);
      end
      n_vec++;
      if (width_q[wb + k] !== exp_hi(eb[k])) begin
        n_err++; $display("FAIL b2b_width bit %0d: got %0d want %0d", k, width_q[wb + k], exp_hi(eb[k]));
      end
      n_vec++;
      if (dec_q[wb + k] !== eb[k]) begin
        n_err++; $display("FAIL b2b_decoded bit %0d: got %0d want %0d", k, dec_q[wb + k], eb[k]);
      end
    end
    n_vec++; if (done_q.size() - db !== 1) begin n_err++; $display("FAIL b2b_done_count: got %0d want 1", done_q.size() - db); end
    if (done_q.size() > db) begin
      n_vec++;
      if (done_q[db] !== t_done) begin n_err++; $display("FAIL b2b_done_cycle: got %0d want %0d", done_q[db], t_done); end
    end
    n_idle = 0;
    foreach (idle_q[i]) if (idle_q[i] >= a0 && idle_q[i] <= t_done) n_idle++;
    n_vec++; if (n_idle !== 1) begin n_err++; $display("FAIL b2b_idle_events: got %0d want 1", n_idle); end
  endtask

  task automatic test_backpressure();
    logic [23:0] px [3];
    int acc [3];
    int rb, wb, db, nr, t_done;
    bit eb[$];
    rb = rise_q.size(); wb = width_q.size(); db = done_q.size();
    for (int i = 0; i < 3; i++) begin
      px[i] = 24'($urandom);
      for (int b = 23; b >= 0; b--) eb.push_back(px[i][b]);
    end
    for (int i = 0; i < 3; i++) push(px[i], (i < 2), acc[i]);
    n_vec++; if (acc[1] !== acc[0] + 2) begin n_err++; $display("FAIL bp_accept2: got %0d want %0d", acc[1], acc[0] + 2); end
    n_vec++; if (acc[2] !== acc[0] + 2 + 24 * BITP) begin n_err++; $display("FAIL bp_accept3: got %0d want %0d", acc[2], acc[0] + 2 + 24 * BITP); end
    t_done = acc[0] + 2 + 72 * BITP + LATCH;
    wait_cyc(t_done + 10);
    nr = rise_q.size() - rb;
    n_vec++; if (nr !== 72) begin n_err++; $display("FAIL bp_rises: got %0d want 72", nr); end
    for (int k = 0; k < 72 && k < nr && wb + k < width_q.size(); k++) begin
      n_vec++;
      if (rise_q[rb + k] !== acc[0] + 3 + k * BITP) begin
        n_err++; $display("FAIL bp_rise bit %0d: got %0d want %0d", k, rise_q[rb + k], acc[0] + 3 + k * BITP);
      end
      n_vec++;
      if (dec_q[wb + k] !== eb[k]) begin
        n_err++; $display("FAIL bp_decoded bit %0d: got %0d want %0d", k, dec_q[wb + k], eb[k]);
      end
    end
    n_vec++; if (done_q.size() - db !== 1) begin n_err++; $display("FAIL bp_done_count: got %0d want 1", done_q.size() - db); end
    if (done_q.size() > db) begin
      n_vec++;
      if (done_q[db] !== t_done) begin n_err++; $display("FAIL bp_done_cycle: got %0d want %0d", done_q[db], t_done); end
    end
  endtask

  task automatic test_bypass();
    logic [23:0] p0, p1;
    int rb, wb, db, acc, nr, t_done;
    bit eb[$];
    p0 = 24'($urandom);
    p1 = 24'h000001;
    rb = rise_q.size(); wb = width_q.size(); db = done_q.size();
    for (int b = 23; b >= 0; b--) eb.push_back(p0[b]);
    for (int b = 23; b >= 0; b--) eb.push_back(p1[b]);
    push(p0, 1'b0, acc);
    wait_cyc(acc + 1 + 24 * BITP);
    pixel_data = p1;
    pixel_valid = 1'b1;
    n_vec++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL byp_ready_eop: got %b want 1", pixel_ready); end
    @(negedge clk);
    pixel_valid = 1'b0;
    n_vec++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL byp_hold_empty: got %b want 1", pixel_ready); end
    t_done = acc + 2 + 48 * BITP + LATCH;
    wait_cyc(t_done + 10);
    nr = rise_q.size() - rb;
    n_vec++; if (nr !== 48) begin n_err++; $display("FAIL byp_rises: got %0d want 48", nr); end
    for (int k = 0; k < 48 && k < nr && wb + k < width_q.size(); k++) begin
      n_vec++;
      if (rise_q[rb + k] !== acc + 3 + k * BITP) begin
        n_err++; $display("FAIL byp_rise bit %0d: got %0d want %0d", k, rise_q[rb + k], acc + 3 + k * BITP);
      end
      n_vec++;
      if (width_q[wb + k] !== exp_hi(eb[k])) begin
        n_err++; $display("FAIL byp_width bit %0d: got %0d want %0d", k, width_q[wb + k], exp_hi(eb[k]));
      end
    end
    n_vec++; if (done_q.size() - db !== 1) begin n_err++; $display("FAIL byp_done_count: got %0d want 1", done_q.size() - db); end
    if (done_q.size() > db) begin
      n_vec++;
      if (done_q[db] !== t_done) begin n_err++; $display("FAIL byp_done_cycle: got %0d want %0d", done_q[db], t_done); end
    end
  endtask

  task automatic test_latch_accept();
    logic [23:0] p0, p1;
    int rb, wb, db, a0, a1, nr, t_done0, t_done1;
    bit eb[$];
    p0 = 24'($urandom);
    p1 = 24'($urandom);
    rb = rise_q.size(); wb = width_q.size(); db = done_q.size();
    for (int b = 23; b >= 0; b--) eb.push_back(p0[b]);
    for (int b = 23; b >= 0; b--) eb.push_back(p1[b]);
    push(p0, 1'b0, a0);
    wait_cyc(a0 + 2 + 24 * BITP + 100);
    push(p1, 1'b0, a1);
    n_vec++; if (a1 !== a0 + 2 + 24 * BITP + 100) begin n_err++; $display("FAIL latch_accept_cycle: got %0d want %0d", a1, a0 + 2 + 24 * BITP + 100); end
    t_done0 = a0 + 2 + 24 * BITP + LATCH;
    t_done1 = t_done0 + 1 + 24 * BITP + LATCH;
    wait_cyc(t_done1 + 10);
    nr = rise_q.size() - rb;
    n_vec++; if (nr !== 48) begin n_err++; $display("FAIL latch_rises: got %0d want 48", nr); end
    for (int k = 0; k < 48 && k < nr && wb + k < width_q.size(); k++) begin
      n_vec++;
      if (rise_q[rb + k] !== ((k < 24) ? a0 + 3 + k * BITP : t_done0 + 2 + (k - 24) * BITP)) begin
        n_err++; $display("FAIL latch_rise bit %0d: got %0d want %0d", k, rise_q[rb + k],
                          (k < 24) ? a0 + 3 + k * BITP : t_done0 + 2 + (k - 24) * BITP);
      end
      n_vec++;
      if (width_q[wb + k] !== exp_hi(eb[k])) begin
        n_err++; $display("FAIL latch_width bit %0d: got %0d want %0d", k, width_q[wb + k], exp_hi(eb[k]));
      end
    end
    n_vec++; if (done_q.size() - db !== 2) begin n_err++; $display("FAIL latch_done_count: got %0d want 2", done_q.size() - db); end
    if (done_q.size() > db + 1) begin
      n_vec++;
      if (done_q[db] !== t_done0) begin n_err++; $display("FAIL latch_done0_cycle: got %0d want %0d", done_q[db], t_done0); end
      n_vec++;
      if (done_q[db + 1] !== t_done1) begin n_err++; $display("FAIL latch_done1_cycle: got %0d want %0d", done_q[db + 1], t_done1); end
    end
  endtask

  task automatic test_reset_mid();
    int acc, a1, rb, db, t0;
    push(24'($urandom) | 24'h002000, 1'b0, acc);
    push(24'($urandom), 1'b0, a1);
    wait_cyc(acc + 3 + 10 * BITP + 5);
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (dout !== 1'b0) begin n_err++; $display("FAIL rst_mid_dout: got %b want 0", dout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_vec++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", pixel_ready); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", done); end
    reset = 1'b0;
    rb = rise_q.size(); db = done_q.size();
    t0 = cyc;
    wait_cyc(t0 + LATCH + 24 * BITP + 50);
    n_vec++; if (rise_q.size() - rb !== 0) begin n_err++; $display("FAIL rst_mid_rises_after: got %0d want 0", rise_q.size() - rb); end
    n_vec++; if (done_q.size() - db !== 0) begin n_err++; $display("FAIL rst_mid_done_after: got %0d want 0", done_q.size() - db); end
  endtask

  initial begin
    test_reset();
    test_single_pixel(24'hA50FF0);
    test_back_to_back(24'h123456, 24'hFFFFFF);
    test_backpressure();
    test_bypass();
    test_latch_accept();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
